// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller driving one external MAC. Optional round/saturate
// output conversion with sat_flag port is enabled by defining FIR_ROUND_SAT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a sample; coefficient writes allowed
// RUN     | one tap per cycle, k = 0..TAPS-1 (load at k=0, accumulate after)
// CAPTURE | MAC result final; convert it into the output register
// OUT     | out_valid held until the consumer takes it
module fir_mac_sequencer #(
    parameter int TAPS        = 16,
    parameter int INPUT_WIDTH = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ACCUM_WIDTH = 35,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 15
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [INPUT_WIDTH-1:0]         in_data,
    input  logic                           coef_we,
    input  logic [$clog2(TAPS)-1:0]        coef_addr,
    input  logic [COEFF_WIDTH-1:0]         coef_wdata,
    output logic                           coef_err,
    output logic                           mac_load,
    output logic                           mac_en,
    output logic [INPUT_WIDTH-1:0]         mac_sample,
    output logic [COEFF_WIDTH-1:0]         mac_coeff,
    input  logic [ACCUM_WIDTH-1:0]         mac_acc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WIDTH-1:0]           out_data,
`ifdef FIR_ROUND_SAT_EN
    output logic                           sat_flag,
`endif
    output logic                           busy
);

    localparam int PW = $clog2(TAPS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           k_q, k_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           newest_q, newest_d;
    logic [INPUT_WIDTH-1:0]  delay_q [TAPS];
    logic [INPUT_WIDTH-1:0]  delay_d [TAPS];
    logic [COEFF_WIDTH-1:0]  coef_q  [TAPS];
    logic [COEFF_WIDTH-1:0]  coef_d  [TAPS];
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic                    sat_q, sat_d;
    logic                    coef_err_q, coef_err_d;

    logic                    coef_ok;
    logic [PW:0]             idx_wide;
    logic [PW-1:0]           rd_idx;
    logic [OUT_WIDTH-1:0]    conv_data;
    logic                    conv_sat;

    // Coefficient writes steal the cycle from the sample port.
    assign in_ready  = (state_q == S_IDLE) && !coef_we;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign coef_err  = coef_err_q;
    assign mac_load  = (state_q == S_RUN) && (k_q == '0);
    assign mac_en    = (state_q == S_RUN) && (k_q != '0);
    assign mac_sample = (state_q == S_RUN) ? delay_q[rd_idx] : '0;
    assign mac_coeff  = (state_q == S_RUN) ? coef_q[k_q]     : '0;
`ifdef FIR_ROUND_SAT_EN
    assign sat_flag  = sat_q;
`endif

    // Tap k reads the sample k steps older than the newest one, modulo TAPS.
    always_comb begin
        if (newest_q >= k_q) begin
            idx_wide = {1'b0, newest_q} - {1'b0, k_q};
        end else begin
            idx_wide = {1'b0, newest_q} + (PW+1)'(TAPS) - {1'b0, k_q};
        end
        rd_idx = PW'(idx_wide);
    end

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [ACCUM_WIDTH:0] RND_HALF = (ACCUM_WIDTH+1)'(1) << (SHIFT-1);
    localparam logic signed [ACCUM_WIDTH:0] SAT_MAX  =
        (ACCUM_WIDTH+1)'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
    localparam logic signed [ACCUM_WIDTH:0] SAT_MIN  = ~SAT_MAX;

    logic signed [ACCUM_WIDTH:0] rnd_sum;
    logic signed [ACCUM_WIDTH:0] rnd_shift;

    always_comb begin
        rnd_sum   = $signed({mac_acc[ACCUM_WIDTH-1], mac_acc}) + RND_HALF;
        rnd_shift = rnd_sum >>> SHIFT;
        conv_sat  = 1'b0;
        conv_data = OUT_WIDTH'(rnd_shift);
        if (rnd_shift > SAT_MAX) begin
            conv_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            conv_sat  = 1'b1;
        end else if (rnd_shift < SAT_MIN) begin
            conv_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            conv_sat  = 1'b1;
        end
    end
`else
    logic signed [ACCUM_WIDTH-1:0] acc_shift;

    always_comb begin
        acc_shift = $signed(mac_acc) >>> SHIFT;
        conv_data = OUT_WIDTH'(acc_shift);
        conv_sat  = 1'b0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wr_ptr_d   = wr_ptr_q;
        newest_d   = newest_q;
        delay_d    = delay_q;
        coef_d     = coef_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        coef_err_d = 1'b0;

        coef_ok = (state_q == S_IDLE) && ({1'b0, coef_addr} < (PW+1)'(TAPS));
        if (coef_we) begin
            if (coef_ok) begin
                coef_d[coef_addr] = coef_wdata;
            end else begin
                coef_err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    delay_d[wr_ptr_q] = in_data;
                    newest_d          = wr_ptr_q;
                    wr_ptr_d          = (wr_ptr_q == PW'(TAPS-1)) ? '0 : wr_ptr_q + PW'(1);
                    k_d               = '0;
                    state_d           = S_RUN;
                end
            end
            S_RUN: begin
                if (k_q == PW'(TAPS-1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    k_d = k_q + PW'(1);
                end
            end
            S_CAPTURE: begin
                out_data_d = conv_data;
                sat_d      = conv_sat;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            wr_ptr_q   <= '0;
            newest_q   <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wr_ptr_q   <= wr_ptr_d;
            newest_q   <= newest_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
            coef_err_q <= coef_err_d;
            delay_q    <= delay_d;
            coef_q     <= coef_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: behavioural MAC plus a sample-history
// FIR reference model; FIR_ROUND_SAT_EN selects the matching conversion and sat_flag checks.
module tb_fir_mac_sequencer;

    localparam int TAPS = 12;
    localparam int IW   = 16;
    localparam int CW   = 16;
    localparam int AW   = 36;
    localparam int OW   = 16;
    localparam int SH   = 15;
    localparam int PW   = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          coef_we = 1'b0;
    logic [PW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic          coef_err;
    logic          mac_load;
    logic          mac_en;
    logic [IW-1:0] mac_sample;
    logic [CW-1:0] mac_coeff;
    logic [AW-1:0] mac_acc;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          busy;
`ifdef FIR_ROUND_SAT_EN
    logic          sat_flag;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fir_mac_sequencer #(
        .TAPS(TAPS), .INPUT_WIDTH(IW), .COEFF_WIDTH(CW),
        .ACCUM_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_err(coef_err),
        .mac_load(mac_load), .mac_en(mac_en),
        .mac_sample(mac_sample), .mac_coeff(mac_coeff), .mac_acc(mac_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef FIR_ROUND_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // External MAC: registered accumulator, one product per clock.
    longint acc_m = 0;
    longint prod_w;
    always_comb prod_w = longint'($signed(mac_sample)) * longint'($signed(mac_coeff));
    always @(posedge clk) begin
        if (mac_load)    acc_m <= prod_w;
        else if (mac_en) acc_m <= acc_m + prod_w;
    end
    always_comb mac_acc = acc_m[AW-1:0];

    // Reference: newest sample at hist[0]; missing history counts as zero.
    longint        coef_m [TAPS];
    longint        hist [$];
    logic [OW-1:0] last_out;

    function automatic void model_out(output logic [OW-1:0] d, output logic s);
        longint y;
        longint r;
        y = 0;
        for (int k = 0; k < TAPS; k++)
            if (k < hist.size()) y += coef_m[k] * hist[k];
`ifdef FIR_ROUND_SAT_EN
        r = (y + (64'sd1 <<< (SH-1))) >>> SH;
        s = 1'b0;
        if (r > (64'sd1 <<< (OW-1)) - 1) begin
            r = (64'sd1 <<< (OW-1)) - 1;
            s = 1'b1;
        end else if (r < -(64'sd1 <<< (OW-1))) begin
            r = -(64'sd1 <<< (OW-1));
            s = 1'b1;
        end
`else
        r = y >>> SH;
        s = 1'b0;
`endif
        d = r[OW-1:0];
    endfunction

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        hist.delete();
        for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [CW-1:0] data, input logic exp_err);
        coef_we    = 1'b1;
        coef_addr  = PW'(addr);
        coef_wdata = data;
        #1;
        chk("in_ready_gated", in_ready, 1'b0);
        @(negedge clk);
        coef_we = 1'b0;
        chk("coef_err", coef_err, exp_err);
        if (!exp_err) coef_m[addr] = longint'($signed(data));
        #1;
    endtask

    task automatic run_sample(input logic [IW-1:0] x, input int hold, input bit poke);
        int n, t, loads, ens, both;
        logic [OW-1:0] ed;
        logic es;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = (hold == 0);
        t = cyc;
        hist.push_front(longint'($signed(x)));
        if (hist.size() > TAPS) void'(hist.pop_back());
        model_out(ed, es);
        @(negedge clk);
        in_valid = 1'b0;
        loads = 0; ens = 0; both = 0; n = 0;
        while (out_valid !== 1'b1 && n < TAPS + 10) begin
            if (mac_load === 1'b1) loads++;
            if (mac_en === 1'b1) ens++;
            if (mac_load === 1'b1 && mac_en === 1'b1) both++;
            if (poke && n == 3) begin
                coef_we    = 1'b1;
                coef_addr  = '0;
                coef_wdata = CW'($urandom);
            end
            @(negedge clk);
            n++;
            if (poke && n == 4) begin
                chk("coef_err_busy", coef_err, 1'b1);
                coef_we = 1'b0;
            end
        end
        chk("out_valid_rise", out_valid, 1'b1);
        chk("latency", cyc - t, TAPS + 2);
        chk("mac_load_count", loads, 1);
        chk("mac_en_count", ens, TAPS - 1);
        chk("load_en_overlap", both, 0);
        chk("out_data", out_data, ed);
`ifdef FIR_ROUND_SAT_EN
        chk("sat_flag", sat_flag, es);
`endif
        last_out = out_data;
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, ed);
                chk("hold_in_ready", in_ready, 1'b0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk("release_valid", out_valid, 1'b0);
            chk("release_ready", in_ready, 1'b1);
        end else begin
            @(negedge clk);
            chk("in_ready_back", in_ready, 1'b1);
            chk("ready_cycle", cyc - t, TAPS + 3);
        end
    endtask

    initial begin
        logic [OW-1:0] exp_imp;
        int n, seen;

        // Reset state
        do_reset();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_mac_load", mac_load, 1'b0);
        chk("rst_mac_en", mac_en, 1'b0);
        chk("rst_mac_sample", mac_sample, '0);
        chk("rst_mac_coeff", mac_coeff, '0);
        chk("rst_coef_err", coef_err, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Impulse through coef[k] = k+1
        for (int k = 0; k < TAPS; k++) write_coef(k, CW'(k + 1), 1'b0);
        for (int i = 0; i < TAPS; i++) begin
            run_sample((i == 0) ? IW'(16'h7FFF) : '0, 0, 1'b0);
`ifdef FIR_ROUND_SAT_EN
            exp_imp = OW'(i + 1);
`else
            exp_imp = OW'(i);
`endif
            chk("impulse", last_out, exp_imp);
        end

        // Back-pressure
        run_sample(IW'($urandom), 10, 1'b0);

        // Coefficient guard: write during RUN, then out-of-range address in IDLE
        run_sample(IW'($urandom), 0, 1'b1);
        write_coef(TAPS, CW'($urandom), 1'b1);
        run_sample(IW'($urandom), 0, 1'b0);

        // Random coefficients and wrap-around of the delay line
        for (int k = 0; k < TAPS; k++) write_coef(k, CW'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) run_sample(IW'($urandom), 0, 1'b0);

        // Reset while RUN is at k=5
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = IW'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("k5_mac_en", mac_en, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_mac_en", mac_en, 1'b0);
        chk("abort_out_data", out_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        hist.delete();
        for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
        seen = 0;
        for (int i = 0; i < TAPS + 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("no_partial_output", seen, 0);
        run_sample(IW'($urandom), 0, 1'b0);

`ifdef FIR_ROUND_SAT_EN
        // Full-scale history with full-scale coefficients clamps high
        for (int k = 0; k < TAPS; k++) write_coef(k, CW'(16'h7FFF), 1'b0);
        for (int i = 0; i < TAPS; i++) run_sample(IW'(16'h7FFF), 0, 1'b0);
        chk("sat_out_data", out_data, OW'(16'h7FFF));
        chk("sat_flag_set", sat_flag, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
